// File: rtl/rr_gather8_4to1.sv
// rr_gather8_4to1 -- four-producer to one-consumer byte gatherer.
//
// Four independent valid/ready byte streams are merged into one registered
// output stream tagged with the source channel. Arbitration is round-robin
// with a per-channel burst allowance: the channel holding priority may pass
// up to BURST_MAX consecutive bytes before priority rotates past it.
//
// Parameters:
//   RR_START  : channel (0..3) holding highest priority after reset
//   BURST_MAX : consecutive bytes per channel before rotation (1..15)
//
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid[3:0]       : per-channel byte valid
//   in_data0..in_data3  : per-channel bytes
//   in_ready[3:0]       : per-channel accept (one-hot or zero)
//   out_valid/out_data/out_ch/out_ready : registered output stream
//
// Optional feature, macro GATHER_SUM_EN:
//   sum_clr (in), sum_out[7:0] (out) -- running mod-256 sum of every byte
//   delivered on the output; sum_clr wins over accumulation.

module mux8_4to1b (
  input  logic [1:0] sel,
  input  logic [7:0] d0,
  input  logic [7:0] d1,
  input  logic [7:0] d2,
  input  logic [7:0] d3,
  output logic [7:0] y
);
  always_comb begin
    case (sel)
      2'd0:    y = d0;
      2'd1:    y = d1;
      2'd2:    y = d2;
      default: y = d3;
    endcase
  end
endmodule

`ifdef GATHER_SUM_EN
module adder8b (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] y
);
  // carry out is intentionally dropped: sum wraps modulo 256
  assign y = a + b;
endmodule
`endif

module rr_gather8_4to1 #(
  parameter int RR_START  = 0,
  parameter int BURST_MAX = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] in_valid,
  input  logic [7:0] in_data0,
  input  logic [7:0] in_data1,
  input  logic [7:0] in_data2,
  input  logic [7:0] in_data3,
  output logic [3:0] in_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic [1:0] out_ch,
`ifdef GATHER_SUM_EN
  input  logic       sum_clr,
  output logic [7:0] sum_out,
`endif
  input  logic       out_ready
);

  localparam logic [1:0] PTR_RST = 2'(RR_START);
  localparam logic [3:0] BMAX    = 4'(BURST_MAX);

  logic       out_valid_q, out_valid_d;
  logic [7:0] out_data_q,  out_data_d;
  logic [1:0] out_ch_q,    out_ch_d;
  logic [1:0] ptr_q,       ptr_d;
  logic [3:0] burst_cnt_q, burst_cnt_d;

  logic       found;
  logic [1:0] grant;
  logic       load_en;
  logic       xfer;
  logic       fire;
  logic [3:0] n_eff;
  logic [7:0] sel_data;

  // Grant: first valid channel scanning from ptr upward, wrapping at 3.
  always_comb begin
    found = 1'b0;
    grant = 2'd0;
    for (int k = 0; k < 4; k++) begin
      if (!found && in_valid[ptr_q + 2'(k)]) begin
        found = 1'b1;
        grant = ptr_q + 2'(k);
      end
    end
  end

  assign load_en = ~out_valid_q | out_ready;
  assign xfer    = found & load_en & ~rst;
  assign fire    = out_valid_q & out_ready;
  // Burst count continues only while the priority holder keeps winning.
  assign n_eff   = (grant == ptr_q) ? burst_cnt_q + 4'd1 : 4'd1;

  mux8_4to1b u_mux (
    .sel (grant),
    .d0  (in_data0),
    .d1  (in_data1),
    .d2  (in_data2),
    .d3  (in_data3),
    .y   (sel_data)
  );

  always_comb begin
    in_ready = 4'b0000;
    if (!rst && found && load_en) in_ready = 4'b0001 << grant;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    ptr_d       = ptr_q;
    burst_cnt_d = burst_cnt_q;
    if (fire) out_valid_d = 1'b0;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_data;
      out_ch_d    = grant;
      if (n_eff == BMAX) begin
        ptr_d       = grant + 2'd1;
        burst_cnt_d = 4'd0;
      end else begin
        ptr_d       = grant;
        burst_cnt_d = n_eff;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      out_ch_q    <= 2'd0;
      ptr_q       <= PTR_RST;
      burst_cnt_q <= 4'd0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      ptr_q       <= ptr_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

`ifdef GATHER_SUM_EN
  logic [7:0] sum_q, sum_d, sum_add;

  adder8b u_add (
    .a (sum_q),
    .b (out_data_q),
    .y (sum_add)
  );

  always_comb begin
    sum_d = sum_q;
    if (sum_clr)   sum_d = 8'h00;
    else if (fire) sum_d = sum_add;
  end

  always_ff @(posedge clk) begin
    if (rst) sum_q <= 8'h00;
    else     sum_q <= sum_d;
  end

  assign sum_out = sum_q;
`endif

endmodule

// File: tb/tb_rr_gather8_4to1.sv
module tb_rr_gather8_4to1;

  localparam int B_START = 1;
  localparam int B_BURST = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- instance A: RR_START=0, BURST_MAX=1 ----------------
  logic       a_rst, a_ordy, a_ov;
  logic [3:0] a_iv, a_ir;
  logic [7:0] a_d [4];
  logic [7:0] a_od;
  logic [1:0] a_och;
`ifdef GATHER_SUM_EN
  logic       a_clr;
  logic [7:0] a_sum;
  logic       b_clr;
  logic [7:0] b_sum;
`endif

  rr_gather8_4to1 #(.RR_START(0), .BURST_MAX(1)) dut_a (
    .clk       (clk),
    .rst       (a_rst),
    .in_valid  (a_iv),
    .in_data0  (a_d[0]),
    .in_data1  (a_d[1]),
    .in_data2  (a_d[2]),
    .in_data3  (a_d[3]),
    .in_ready  (a_ir),
    .out_valid (a_ov),
    .out_data  (a_od),
    .out_ch    (a_och),
`ifdef GATHER_SUM_EN
    .sum_clr   (a_clr),
    .sum_out   (a_sum),
`endif
    .out_ready (a_ordy)
  );

  // ---------------- instance B: RR_START=1, BURST_MAX=3 ----------------
  logic       b_rst, b_ordy, b_ov;
  logic [3:0] b_iv, b_ir;
  logic [7:0] b_d [4];
  logic [7:0] b_od;
  logic [1:0] b_och;

  rr_gather8_4to1 #(.RR_START(B_START), .BURST_MAX(B_BURST)) dut_b (
    .clk       (clk),
    .rst       (b_rst),
    .in_valid  (b_iv),
    .in_data0  (b_d[0]),
    .in_data1  (b_d[1]),
    .in_data2  (b_d[2]),
    .in_data3  (b_d[3]),
    .in_ready  (b_ir),
    .out_valid (b_ov),
    .out_data  (b_od),
    .out_ch    (b_och),
`ifdef GATHER_SUM_EN
    .sum_clr   (b_clr),
    .sum_out   (b_sum),
`endif
    .out_ready (b_ordy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- table vectors for instance A ----------------
  typedef struct {
    logic        rst;
    logic [3:0]  iv;
    logic [31:0] d;      // {d3,d2,d1,d0}
    logic        ordy;
    logic [3:0]  ex_ir;  // before the edge
    logic        ex_ov;  // after the edge
    logic [1:0]  ex_ch;
    logic [7:0]  ex_dat;
  } vec_t;

  vec_t tbl [19];

  // ---------------- reference model for instance B ----------------
  // Output register modelled as a 0/1-entry holding slot; priority as a
  // pointer plus count of consecutive wins by the pointer's channel.
  int         m_ptr, m_cnt;
  bit         m_ov;
  int         m_ch;
  logic [7:0] m_dat;
  bit         p_v [4];
  logic [7:0] p_d [4];

  task automatic b_step(input bit rst, input bit ordy);
    int g;
    bit le;
    logic [3:0] exp_ir;
    b_rst  = rst;
    b_ordy = ordy;
    for (int c = 0; c < 4; c++) begin
      b_iv[c] = p_v[c];
      b_d[c]  = p_d[c];
    end
    g = -1;
    for (int k = 3; k >= 0; k--)
      if (p_v[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
    le = !m_ov || ordy;
    exp_ir = (!rst && g >= 0 && le) ? 4'(1 << g) : 4'b0000;
    #2;
    chk("b_in_ready", 32'(b_ir), 32'(exp_ir));
    @(posedge clk);
    if (rst) begin
      m_ov = 0; m_dat = 8'h00; m_ch = 0; m_ptr = B_START; m_cnt = 0;
    end else begin
      if (m_ov && ordy) m_ov = 0;
      if (g >= 0 && le) begin
        int n;
        m_ov = 1; m_ch = g; m_dat = p_d[g];
        p_v[g] = 0;
        n = (g == m_ptr) ? m_cnt + 1 : 1;
        if (n == B_BURST) begin m_ptr = (g + 1) % 4; m_cnt = 0; end
        else begin m_ptr = g; m_cnt = n; end
      end
    end
    #1;
    chk("b_out_valid", 32'(b_ov), 32'(m_ov));
    if (m_ov || rst) begin
      chk("b_out_ch", 32'(b_och), 32'(m_ch));
      chk("b_out_data", 32'(b_od), 32'(m_dat));
    end
  endtask

`ifdef GATHER_SUM_EN
  task automatic a_cyc(input logic [3:0] iv, input logic [31:0] d, input bit ordy,
                       input bit clr, input logic [7:0] ex_sum, input string nm);
    a_rst = 0; a_iv = iv; a_ordy = ordy; a_clr = clr;
    for (int c = 0; c < 4; c++) a_d[c] = d[c*8 +: 8];
    @(posedge clk); #1;
    chk(nm, 32'(a_sum), 32'(ex_sum));
  endtask
`endif

  initial begin
    int bseq [10];
    a_rst = 1; a_iv = 0; a_ordy = 0;
    b_rst = 1; b_iv = 0; b_ordy = 0;
    for (int c = 0; c < 4; c++) begin a_d[c] = 0; b_d[c] = 0; p_v[c] = 0; p_d[c] = 0; end
`ifdef GATHER_SUM_EN
    a_clr = 0; b_clr = 0;
`endif

    //              rst iv       data          ordy ex_ir    ov ch    dat
    tbl[0]  = '{1'b1, 4'b1111, 32'h40302010, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00};
    tbl[1]  = '{1'b0, 4'b1111, 32'h40302010, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h10};
    tbl[2]  = '{1'b0, 4'b1111, 32'h40302010, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h20};
    tbl[3]  = '{1'b0, 4'b1111, 32'h40302010, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h30};
    tbl[4]  = '{1'b0, 4'b1111, 32'h40302010, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h40};
    tbl[5]  = '{1'b0, 4'b1111, 32'h40302010, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h10};
    tbl[6]  = '{1'b0, 4'b0100, 32'h005A0000, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h5A};
    tbl[7]  = '{1'b0, 4'b0100, 32'h005A0000, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h5A};
    tbl[8]  = '{1'b0, 4'b0100, 32'h005A0000, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h5A};
    tbl[9]  = '{1'b0, 4'b0010, 32'h0000A500, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hA5};
    tbl[10] = '{1'b0, 4'b0010, 32'h00001100, 1'b0, 4'b0000, 1'b1, 2'd1, 8'hA5};
    tbl[11] = '{1'b0, 4'b0010, 32'h00001100, 1'b0, 4'b0000, 1'b1, 2'd1, 8'hA5};
    tbl[12] = '{1'b0, 4'b0010, 32'h00001100, 1'b0, 4'b0000, 1'b1, 2'd1, 8'hA5};
    tbl[13] = '{1'b0, 4'b0010, 32'h00001100, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h11};
    tbl[14] = '{1'b0, 4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00};
    tbl[15] = '{1'b0, 4'b0000, 32'h00000000, 1'b0, 4'b0000, 1'b0, 2'd0, 8'h00};
    tbl[16] = '{1'b0, 4'b1111, 32'h40302010, 1'b0, 4'b0100, 1'b1, 2'd2, 8'h30};
    tbl[17] = '{1'b1, 4'b1111, 32'h40302010, 1'b0, 4'b0000, 1'b0, 2'd0, 8'h00};
    tbl[18] = '{1'b0, 4'b1111, 32'h40302010, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h10};

    @(negedge clk);
    for (int i = 0; i < 19; i++) begin
      a_rst = tbl[i].rst; a_iv = tbl[i].iv; a_ordy = tbl[i].ordy;
      for (int c = 0; c < 4; c++) a_d[c] = tbl[i].d[c*8 +: 8];
      #2;
      chk($sformatf("a_in_ready[%0d]", i), 32'(a_ir), 32'(tbl[i].ex_ir));
      @(posedge clk); #1;
      chk($sformatf("a_out_valid[%0d]", i), 32'(a_ov), 32'(tbl[i].ex_ov));
      if (tbl[i].ex_ov || tbl[i].rst) begin
        chk($sformatf("a_out_ch[%0d]", i), 32'(a_och), 32'(tbl[i].ex_ch));
        chk($sformatf("a_out_data[%0d]", i), 32'(a_od), 32'(tbl[i].ex_dat));
      end
    end

`ifdef GATHER_SUM_EN
    // held byte 0x10 fires with clr in the same cycle: clear wins
    a_cyc(4'b0000, 32'h0,        1'b1, 1'b1, 8'h00, "sum_clr_vs_fire");
    a_cyc(4'b0001, 32'h000000F0, 1'b1, 1'b0, 8'h00, "sum_idle");
    a_cyc(4'b0010, 32'h00002000, 1'b1, 1'b0, 8'hF0, "sum_f0");
    a_cyc(4'b0000, 32'h0,        1'b1, 1'b0, 8'h10, "sum_wrap");
    a_cyc(4'b0001, 32'h00000033, 1'b0, 1'b1, 8'h00, "sum_clr_pulse");
    a_cyc(4'b0000, 32'h0,        1'b1, 1'b1, 8'h00, "sum_clr_fire2");
`endif

    // instance B: reset, then burst sequence with every channel valid
    m_ptr = B_START; m_cnt = 0; m_ov = 0; m_ch = 0; m_dat = 0;
    b_step(1'b1, 1'b1);
    bseq = '{1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
    for (int i = 0; i < 10; i++) begin
      for (int c = 0; c < 4; c++) begin p_v[c] = 1; p_d[c] = 8'(8'h11 * (c + 1)); end
      b_step(1'b0, 1'b1);
      chk($sformatf("b_burst_seq[%0d]", i), 32'(b_och), 32'(bseq[i]));
    end

    // instance B: randomized traffic with held-until-accepted producers
    for (int t = 0; t < 600; t++) begin
      for (int c = 0; c < 4; c++)
        if (!p_v[c] && ($urandom_range(0, 99) < 45)) begin
          p_v[c] = 1; p_d[c] = 8'($urandom);
        end
      b_step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 70);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
